cache_miss_ctrl: RTL

Sequencing controller for the 2-way set-associative cache (32-byte address space, 5-bit address, 8-bit data, one byte per line). Accepts one processor request at a time and performs the tag lookup. On a miss it writes back a dirty victim to main memory, fetches the missing byte, fills the chosen way and answers the requester. It sits between the board-level request source (switches/keys or a CPU stub) and the cache arrays plus main memory.

---
 rtl/cache_miss_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: request sequencer for a 2-way set-associative cache with
// one byte per line. Performs the tag lookup, writes back a dirty victim,
// fetches the missing byte, fills the victim way and answers the requester.
//
// Handshakes:
//   - Requester: a request is accepted on a rising edge where req_valid and
//     req_ready are both high. The requester holds req_valid and its payload
//     until that edge. req_ready is high only while the controller is idle.
//   - Response: resp_valid is a one-cycle pulse. resp_rdata and resp_hit are
//     meaningful only while resp_valid is high.
//   - Memory: mem_req and its payload stay asserted until a cycle in which
//     mem_ack is high. That cycle completes the transfer, and mem_rdata is
//     taken in the same cycle. mem_ack is ignored while no transfer is pending.
//
// Optional build macro: CACHE_MISS_CTRL_STATS_EN adds saturating 8-bit
// hit/miss/write-back counters on extra output ports.
//
// dbg_state exposes the FSM state:
//   0=IDLE 1=LOOKUP 2=WRITEBACK 3=FETCH 4=FILL 5=RESPOND.

module cache_miss_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  // requester
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  // cache arrays
  output logic [ADDR_W-1:0] c_addr,
  input  logic              c_hit,
  input  logic              c_hit_way,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_victim_way,
  input  logic              c_victim_dirty,
  input  logic [ADDR_W-3:0] c_victim_tag,
  input  logic [DATA_W-1:0] c_victim_rdata,
  output logic              c_way,
  output logic              c_we_data,
  output logic              c_we_tag,
  output logic              c_dirty,
  output logic [DATA_W-1:0] c_wdata,
  output logic              c_lru_upd,
  // main memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_MISS_CTRL_STATS_EN
  output logic [7:0]        stat_hits,
  output logic [7:0]        stat_misses,
  output logic [7:0]        stat_wbacks,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FETCH     = 3'd3,
    S_FILL      = 3'd4,
    S_RESPOND   = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_victim_way;
  logic [ADDR_W-3:0]   r_victim_tag;
  logic [DATA_W-1:0]   r_victim_data;
  logic [DATA_W-1:0]   r_fetch_data;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_hit;

  // A write miss fills with the requester's byte; a read miss fills with the
  // fetched byte.
  logic [DATA_W-1:0]   w_fill_wdata;
  assign w_fill_wdata = r_we ? r_wdata : r_fetch_data;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_hit   = r_resp_hit;
  assign c_addr     = r_addr;
  assign dbg_state  = r_state;

  // Main sequencer.
  // Latches the request and the victim. Produces the registered
  // ready/response outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_victim_way  <= 1'b0;
      r_victim_tag  <= '0;
      r_victim_data <= '0;
      r_fetch_data  <= '0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_hit    <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (c_hit) begin
            r_resp_rdata <= r_we ? r_wdata : c_rdata;
            r_resp_hit   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESPOND;
          end else begin
            r_victim_way  <= c_victim_way;
            r_victim_tag  <= c_victim_tag;
            r_victim_data <= c_victim_rdata;
            r_resp_hit    <= 1'b0;
            r_state       <= c_victim_dirty ? S_WRITEBACK : S_FETCH;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_fetch_data <= mem_rdata;
            r_state      <= S_FILL;
          end
        end
        S_FILL: begin
          r_resp_rdata <= w_fill_wdata;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESPOND;
        end
        S_RESPOND: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Cache and memory strobes, decoded from the current state.
  // The hit path reacts to the array's combinational tag match. All strobes
  // follow the state register, so reset drops them immediately.
  always_comb begin
    c_way     = 1'b0;
    c_we_data = 1'b0;
    c_we_tag  = 1'b0;
    c_dirty   = 1'b0;
    c_wdata   = '0;
    c_lru_upd = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_LOOKUP: begin
        if (c_hit) begin
          c_lru_upd = 1'b1;
          c_way     = c_hit_way;
          if (r_we) begin
            c_we_data = 1'b1;
            c_dirty   = 1'b1;
            c_wdata   = r_wdata;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_victim_tag, r_addr[1:0]};
        mem_wdata = r_victim_data;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_addr;
      end
      S_FILL: begin
        c_way     = r_victim_way;
        c_we_tag  = 1'b1;
        c_we_data = 1'b1;
        c_lru_upd = 1'b1;
        c_wdata   = w_fill_wdata;
        c_dirty   = r_we;
      end
      default: begin
      end
    endcase
  end

`ifdef CACHE_MISS_CTRL_STATS_EN
  logic [7:0] r_stat_hits;
  logic [7:0] r_stat_misses;
  logic [7:0] r_stat_wbacks;

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_wbacks = r_stat_wbacks;

  // Saturating event counters.
  // Hits and misses are counted at lookup time. Write-backs are counted when
  // their memory acknowledge arrives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_wbacks <= '0;
    end else begin
      if (r_state == S_LOOKUP) begin
        if (c_hit) begin
          if (r_stat_hits != 8'hFF) r_stat_hits <= r_stat_hits + 8'd1;
        end else begin
          if (r_stat_misses != 8'hFF) r_stat_misses <= r_stat_misses + 8'd1;
        end
      end
      if ((r_state == S_WRITEBACK) && mem_ack && (r_stat_wbacks != 8'hFF))
        r_stat_wbacks <= r_stat_wbacks + 8'd1;
    end
  end
`endif

endmodule
